// File: rtl/sdf_stage_seq.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: FILL / BFLY / DRAIN control.
// Latency: 1 cycle. All outputs are registered and present a transfer from the edge that accepts it.
// Backpressure: ready_o is low for DEPTH cycles while draining and for one cycle after reset.
// Optional macro SDF_AUTO_FLUSH_EN: an idle input cycle at a frame boundary also starts a drain.
module sdf_stage_seq #(
  parameter int DEPTH     = 16,
  parameter int DW        = 16,
  parameter int TW_W      = 5,
  parameter int TW_STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [DW-1:0]   data_in_r,
  input  logic [DW-1:0]   data_in_i,
  input  logic            flush_i,
  output logic [DW-1:0]   data_out_r,
  output logic [DW-1:0]   data_out_i,
  output logic [1:0]      state,
  output logic            sr_en,
  output logic [TW_W-1:0] tw_idx,
  output logic            valid_o,
  output logic            frame_done
);

  localparam int PW  = $clog2(2 * DEPTH);
  localparam int DCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FILL  = 2'b01;
  localparam logic [1:0] ST_BFLY  = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  localparam logic [PW-1:0]  POS_HALF      = PW'(DEPTH);
  localparam logic [PW-1:0]  POS_FILL_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0]  POS_LAST      = PW'(2 * DEPTH - 1);
  localparam logic [DCW-1:0] DRAIN_LAST    = DCW'(DEPTH - 1);

  // Frame position, pending-differences flag and drain cycle index.
  logic [PW-1:0]   pos_q, pos_d;
  logic            pending_q, pending_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;

  // Registered outputs.
  logic            ready_q, ready_d;
  logic [1:0]      state_q, state_d;
  logic            sr_en_q, sr_en_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [TW_W-1:0] tw_q, tw_d;
  logic [DW-1:0]   dr_q, dr_d;
  logic [DW-1:0]   di_q, di_d;

  logic xfer;
  logic flush_cond;

  // Twiddle index for difference sample k, wrapping modulo 2^TW_W.
  function automatic logic [TW_W-1:0] tw_of(input logic [31:0] k);
    tw_of = TW_W'(k * TW_STRIDE);
  endfunction

  // Transfer and flush qualification; the optional mode treats an idle input as a flush request.
  always_comb begin
    xfer = valid_i && ready_q;
`ifdef SDF_AUTO_FLUSH_EN
    flush_cond = flush_i || !valid_i;
`else
    flush_cond = flush_i;
`endif
  end

  // Next-state: drain sequencing has priority, then transfers, then drain start, else idle.
  always_comb begin
    pos_d     = pos_q;
    pending_d = pending_q;
    dcnt_d    = dcnt_q;
    ready_d   = 1'b1;
    state_d   = ST_IDLE;
    sr_en_d   = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    tw_d      = '0;
    dr_d      = '0;
    di_d      = '0;

    if (state_q == ST_DRAIN) begin
      if (dcnt_q == DRAIN_LAST) begin
        // Last drain cycle has been presented; reopen the input.
        dcnt_d = '0;
      end else begin
        dcnt_d  = dcnt_q + DCW'(1);
        ready_d = 1'b0;
        state_d = ST_DRAIN;
        sr_en_d = 1'b1;
        valid_d = 1'b1;
        tw_d    = tw_of(32'(dcnt_d));
        if (dcnt_d == DRAIN_LAST) begin
          done_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
    end else if (xfer) begin
      dr_d    = data_in_r;
      di_d    = data_in_i;
      sr_en_d = 1'b1;
      pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      if (pos_q < POS_HALF) begin
        // First half: samples go into the delay line; the previous frame's
        // differences come out alongside them if any are pending.
        state_d = ST_FILL;
        if (pending_q) begin
          valid_d = 1'b1;
          tw_d    = tw_of(32'(pos_q));
          if (pos_q == POS_FILL_LAST) begin
            done_d    = 1'b1;
            pending_d = 1'b0;
          end
        end
      end else begin
        // Second half: butterfly sums emerge; differences wait in the delay line.
        state_d = ST_BFLY;
        valid_d = 1'b1;
        if (pos_q == POS_LAST) begin
          pending_d = 1'b1;
        end
      end
    end else if (pending_q && (pos_q == '0) && flush_cond) begin
      // Frame boundary with differences still in the delay line: push them out.
      ready_d = 1'b0;
      state_d = ST_DRAIN;
      sr_en_d = 1'b1;
      valid_d = 1'b1;
      tw_d    = tw_of(32'd0);
      dcnt_d  = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q     <= '0;
      pending_q <= 1'b0;
      dcnt_q    <= '0;
      ready_q   <= 1'b0;
      state_q   <= ST_IDLE;
      sr_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      tw_q      <= '0;
      dr_q      <= '0;
      di_q      <= '0;
    end else begin
      pos_q     <= pos_d;
      pending_q <= pending_d;
      dcnt_q    <= dcnt_d;
      ready_q   <= ready_d;
      state_q   <= state_d;
      sr_en_q   <= sr_en_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      tw_q      <= tw_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
    end
  end

  assign ready_o    = ready_q;
  assign state      = state_q;
  assign sr_en      = sr_en_q;
  assign valid_o    = valid_q;
  assign frame_done = done_q;
  assign tw_idx     = tw_q;
  assign data_out_r = dr_q;
  assign data_out_i = di_q;

endmodule

// File: tb/tb_sdf_stage_seq.sv
// Directed bench for sdf_stage_seq: frames, gaps, flush/drain, flush-vs-transfer and reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Expectations follow the default parameters and adapt to SDF_AUTO_FLUSH_EN where behaviour differs.
module tb_sdf_stage_seq;

  localparam int DEPTH     = 16;
  localparam int DW        = 16;
  localparam int TW_W      = 5;
  localparam int TW_STRIDE = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [DW-1:0]   data_in_r = '0;
  logic [DW-1:0]   data_in_i = '0;
  logic            ready_o;
  logic [DW-1:0]   data_out_r;
  logic [DW-1:0]   data_out_i;
  logic [1:0]      state;
  logic            sr_en;
  logic [TW_W-1:0] tw_idx;
  logic            valid_o;
  logic            frame_done;

  int checks = 0;
  int errors = 0;

  sdf_stage_seq #(
    .DEPTH(DEPTH), .DW(DW), .TW_W(TW_W), .TW_STRIDE(TW_STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_in_r(data_in_r), .data_in_i(data_in_i), .flush_i(flush_i),
    .data_out_r(data_out_r), .data_out_i(data_out_i), .state(state),
    .sr_en(sr_en), .tw_idx(tw_idx), .valid_o(valid_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tg, input logic [1:0] st, input logic rdy, input logic sr,
                         input logic vo, input logic [TW_W-1:0] tw, input logic [DW-1:0] dr,
                         input logic [DW-1:0] di, input logic fd);
    check({tg, ".state"}, 32'(state), 32'(st));
    check({tg, ".ready"}, 32'(ready_o), 32'(rdy));
    check({tg, ".sr_en"}, 32'(sr_en), 32'(sr));
    check({tg, ".valid"}, 32'(valid_o), 32'(vo));
    check({tg, ".tw"}, 32'(tw_idx), 32'(tw));
    check({tg, ".dr"}, 32'(data_out_r), 32'(dr));
    check({tg, ".di"}, 32'(data_out_i), 32'(di));
    check({tg, ".done"}, 32'(frame_done), 32'(fd));
  endtask

  // Sends positions first..last of a frame; sample p is (base+p, -(base+p)).
  // With gaps set, valid_i drops for 3 cycles before pos 5 and 5 cycles before pos 20.
  task automatic frame(input int base, input logic pend, input logic gaps,
                       input int first, input int last);
    logic [DW-1:0]   vr;
    logic [DW-1:0]   vi;
    logic [TW_W-1:0] tw;
    for (int p = first; p <= last; p++) begin
      if (gaps && (p == 5 || p == 20)) begin
        valid_i = 1'b0;
        repeat ((p == 5) ? 3 : 5) begin
          cyc();
          chk_out("gap", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
      end
      vr = DW'(base + p);
      vi = DW'(-(base + p));
      valid_i   = 1'b1;
      data_in_r = vr;
      data_in_i = vi;
      cyc();
      if (p < DEPTH) begin
        tw = pend ? TW_W'(p * TW_STRIDE) : TW_W'(0);
        chk_out("fill", 2'b01, 1'b1, 1'b1, pend, tw, vr, vi, pend && (p == DEPTH - 1));
      end else begin
        chk_out("bfly", 2'b10, 1'b1, 1'b1, 1'b1, '0, vr, vi, 1'b0);
      end
    end
  endtask

  // Expects DEPTH drain cycles starting at the next edge; raises valid_i with
  // the held sample during drain cycle 3, which must wait for ready_o.
  task automatic drain(input logic [DW-1:0] held_r, input logic [DW-1:0] held_i);
    for (int k = 0; k < DEPTH; k++) begin
      cyc();
      flush_i = 1'b0;
      chk_out("drain", 2'b11, 1'b0, 1'b1, 1'b1, TW_W'(k * TW_STRIDE), '0, '0, k == DEPTH - 1);
      if (k == 2) begin
        valid_i   = 1'b1;
        data_in_r = held_r;
        data_in_i = held_i;
      end
    end
    cyc();
    chk_out("drain_end", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    cyc();
    cyc();
    chk_out("rst", 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_out("rel", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    // Two back-to-back contiguous frames; the second emits the first's differences.
    frame(100, 1'b0, 1'b0, 0, 31);
    frame(200, 1'b1, 1'b0, 0, 31);

    // Pending differences wait, then drain on flush (or on the idle cycle in auto mode).
    valid_i = 1'b0;
`ifndef SDF_AUTO_FLUSH_EN
    repeat (2) begin
      cyc();
      chk_out("wait", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    end
`endif
    flush_i = 1'b1;
    drain(DW'(300), DW'(-300));

    // Gapped frames: first with nothing pending, second emitting differences.
    frame(300, 1'b0, 1'b1, 0, 31);
    frame(400, 1'b1, 1'b1, 0, 31);

    // Transfer and flush together at a boundary: the transfer wins.
    flush_i = 1'b1;
    frame(500, 1'b1, 1'b0, 0, 2);

    // Flush mid-frame is ignored.
    valid_i = 1'b0;
    repeat (2) begin
      cyc();
      chk_out("midflush", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    end
    flush_i = 1'b0;
    frame(500, 1'b1, 1'b0, 3, 20);

    // Reset during BFLY at pos 20 discards the frame.
    rst_n = 1'b0;
    cyc();
    chk_out("rst_bfly", 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    chk_out("rel2", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cyc();
    chk_out("noflush", 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    flush_i = 1'b0;

    // Fresh frame: pos restarted at 0 and no pending differences.
    frame(700, 1'b0, 1'b0, 0, 31);
    valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
